n101_wishb8_uart: RTL



---
 rtl/n101_wishb8_uart_if.sv | 23 ++
 rtl/n101_wishb8_uart.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/n101_wishb8_uart_if.sv
// Wishbone 8-bit bus bundle between the ICB32-to-Wishbone8 bridge (master)
// and the n101_wishb8_uart peripheral (slave).
interface n101_wishb8_uart_if #(
   parameter int AW = 32
);
   logic [AW-1:0] wb_adr;
   logic [7:0]    wb_dat_w;
   logic [7:0]    wb_dat_r;
   logic          wb_we;
   logic          wb_stb;
   logic          wb_cyc;
   logic          wb_ack;

   modport master (
      output wb_adr, wb_dat_w, wb_we, wb_stb, wb_cyc,
      input  wb_dat_r, wb_ack
   );

   modport slave (
      input  wb_adr, wb_dat_w, wb_we, wb_stb, wb_cyc,
      output wb_dat_r, wb_ack
   );
endinterface

// File: rtl/n101_wishb8_uart.sv
// n101_wishb8_uart: 8-bit Wishbone slave UART, 8N1, level RX interrupt.
// Registers (adr[2:0]): 0 DATA, 1 STATUS, 2 CTRL, 3 DIV_LO, 4 DIV_HI.
// Bit period is DIV+1 clocks; the baud counter reloads from DIV at every bit.
// Optional build macro N101_WB8_UART_RXFIFO_EN turns the single RX holding
// register into a 4-entry FIFO and enables STATUS.rx_full.
module n101_wishb8_uart #(
   parameter int          AW      = 32,
   parameter logic [15:0] DIV_RST = 16'd433
) (
   input  logic              clk,
   input  logic              rst_n,
   n101_wishb8_uart_if.slave wb,
   output logic              uart_txd,
   input  logic              uart_rxd,
   output logic              uart_irq
);

   localparam logic [2:0] REG_DATA   = 3'd0;
   localparam logic [2:0] REG_STATUS = 3'd1;
   localparam logic [2:0] REG_CTRL   = 3'd2;
   localparam logic [2:0] REG_DIV_LO = 3'd3;
   localparam logic [2:0] REG_DIV_HI = 3'd4;

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // ---------------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------------
   logic [AW-1:0] adr_full;
   logic [2:0]    adr;
   logic          unused_adr;

   assign adr_full   = wb.wb_adr;
   assign adr        = adr_full[2:0];
   assign unused_adr = ^adr_full[AW-1:3];

   logic       ack_q;
   logic [7:0] dat_r_q;
   logic       pop_ok_q;
   logic       req;
   logic       wr_acc;
   logic       rd_acc;
   logic [7:0] rd_mux;

   // A new request is only taken when no ack is outstanding, so held
   // strobes are acked every other cycle.
   assign req    = wb.wb_stb & wb.wb_cyc & ~ack_q;
   assign wr_acc = ack_q & wb.wb_stb & wb.wb_cyc & wb.wb_we;
   assign rd_acc = ack_q & wb.wb_stb & wb.wb_cyc & ~wb.wb_we;

   assign wb.wb_ack   = ack_q;
   assign wb.wb_dat_r = dat_r_q;

   // Control / status state
   logic [15:0] div;
   logic [2:0]  ctrl;
   logic        rx_overrun;
   logic        frame_err;
   logic        tx_busy;
   logic        rx_valid;
   logic        rx_full;
   logic [7:0]  rx_head;
   logic        rx_pop;
   logic        rx_deliver;
   logic        rx_stop_bad;
   logic        ovr_set;
   logic [7:0]  rx_sh;

   // Read data mux; reads of unmapped addresses return zero.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case leaves it unassigned and a latch is inferred.
      rd_mux = 8'h00;
      case (adr)
         REG_DATA:   rd_mux = rx_head;
         REG_STATUS: rd_mux = {3'b000, rx_full, frame_err, rx_overrun, rx_valid, tx_busy};
         REG_CTRL:   rd_mux = {5'b00000, ctrl};
         REG_DIV_LO: rd_mux = div[7:0];
         REG_DIV_HI: rd_mux = div[15:8];
         default:    rd_mux = 8'h00;
      endcase
   end

   // Registered ack and read data; the pop decision is captured together
   // with the data so a byte arriving in between is never popped unread.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: state registers use non-blocking assignments so every flop
         // samples the pre-edge values regardless of statement order.
         ack_q    <= 1'b0;
         dat_r_q  <= 8'h00;
         pop_ok_q <= 1'b0;
      end else begin
         ack_q    <= req;
         dat_r_q  <= req ? rd_mux : 8'h00;
         pop_ok_q <= req & ~wb.wb_we & (adr == REG_DATA) & rx_valid;
      end
   end

   assign rx_pop = rd_acc & pop_ok_q;

   // Writable configuration registers, updated in the ack cycle only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div  <= DIV_RST;
         ctrl <= 3'b000;
      end else if (wr_acc) begin
         case (adr)
            REG_CTRL:   ctrl      <= wb.wb_dat_w[2:0];
            REG_DIV_LO: div[7:0]  <= wb.wb_dat_w;
            REG_DIV_HI: div[15:8] <= wb.wb_dat_w;
            default:    ;
         endcase
      end
   end

   // Sticky error flags: set by the receiver, cleared by writing 1 to STATUS.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_overrun <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         if (ovr_set)
            rx_overrun <= 1'b1;
         else if (wr_acc && adr == REG_STATUS && wb.wb_dat_w[2])
            rx_overrun <= 1'b0;
         if (rx_deliver && rx_stop_bad)
            frame_err <= 1'b1;
         else if (wr_acc && adr == REG_STATUS && wb.wb_dat_w[3])
            frame_err <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Transmitter
   // ---------------------------------------------------------------------
   tx_state_t   tx_state;
   tx_state_t   tx_state_n;
   logic [15:0] tx_cnt;
   logic [2:0]  tx_bit;
   logic [7:0]  tx_sh;
   logic        tx_tick;
   logic        tx_load;
   logic        txd_q;
   logic        txd_n;

   assign tx_tick  = (tx_cnt == 16'd0);
   assign tx_busy  = (tx_state != TX_IDLE);
   assign tx_load  = wr_acc & (adr == REG_DATA) & ctrl[0] & ~tx_busy;
   assign uart_txd = txd_q;

   // TX next state and next serial level (registered so txd never glitches).
   always_comb begin
      tx_state_n = tx_state;
      txd_n      = txd_q;
      case (tx_state)
         TX_IDLE: begin
            txd_n = 1'b1;
            if (tx_load) begin
               tx_state_n = TX_START;
               txd_n      = 1'b0;
            end
         end
         TX_START: begin
            if (tx_tick) begin
               tx_state_n = TX_DATA;
               txd_n      = tx_sh[0];
            end
         end
         TX_DATA: begin
            if (tx_tick) begin
               if (tx_bit == 3'd7) begin
                  tx_state_n = TX_STOP;
                  txd_n      = 1'b1;
               end else begin
                  txd_n = tx_sh[1];
               end
            end
         end
         TX_STOP: begin
            txd_n = 1'b1;
            if (tx_tick)
               tx_state_n = TX_IDLE;
         end
         default: begin
            tx_state_n = TX_IDLE;
            txd_n      = 1'b1;
         end
      endcase
   end

   // TX state, serial output, bit timer and shifter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= TX_IDLE;
         txd_q    <= 1'b1;
         tx_cnt   <= 16'd0;
         tx_bit   <= 3'd0;
         tx_sh    <= 8'h00;
      end else begin
         tx_state <= tx_state_n;
         txd_q    <= txd_n;
         if (tx_load) begin
            tx_sh  <= wb.wb_dat_w;
            tx_cnt <= div;
            tx_bit <= 3'd0;
         end else if (tx_busy) begin
            if (tx_tick) begin
               tx_cnt <= div;
               if (tx_state == TX_DATA) begin
                  tx_sh  <= {1'b0, tx_sh[7:1]};
                  tx_bit <= tx_bit + 3'd1;
               end
            end else begin
               tx_cnt <= tx_cnt - 16'd1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Receiver
   // ---------------------------------------------------------------------
   rx_state_t   rx_state;
   rx_state_t   rx_state_n;
   logic        rxd_s1;
   logic        rxd_s2;
   logic        rxd_d;
   logic        rx_fall;
   logic        rx_tick;
   logic [15:0] rx_cnt;
   logic [2:0]  rx_bit;
   logic [16:0] div_p1;
   logic [15:0] rx_half;

   assign rx_fall     = rxd_d & ~rxd_s2;
   assign rx_tick     = (rx_cnt == 16'd0);
   assign div_p1      = {1'b0, div} + 17'd1;
   assign rx_half     = 16'(div_p1 >> 1) - 16'd1;
   assign rx_stop_bad = ~rxd_s2;

   // Two-flop synchronizer plus one delay flop for falling-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_s1 <= 1'b1;
         rxd_s2 <= 1'b1;
         rxd_d  <= 1'b1;
      end else begin
         rxd_s1 <= uart_rxd;
         rxd_s2 <= rxd_s1;
         rxd_d  <= rxd_s2;
      end
   end

   // RX next state; clearing rx_en drops any frame in progress.
   always_comb begin
      rx_state_n = rx_state;
      rx_deliver = 1'b0;
      if (!ctrl[1]) begin
         rx_state_n = RX_IDLE;
      end else begin
         case (rx_state)
            RX_IDLE:  if (rx_fall) rx_state_n = RX_START;
            RX_START: if (rx_tick) rx_state_n = rxd_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_state_n = RX_STOP;
            RX_STOP: begin
               if (rx_tick) begin
                  rx_state_n = RX_IDLE;
                  rx_deliver = 1'b1;
               end
            end
            default:  rx_state_n = RX_IDLE;
         endcase
      end
   end

   // RX state, mid-bit sample timer and data shifter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= 16'd0;
         rx_bit   <= 3'd0;
         rx_sh    <= 8'h00;
      end else begin
         rx_state <= rx_state_n;
         if (rx_state == RX_IDLE) begin
            rx_cnt <= rx_half;
            rx_bit <= 3'd0;
         end else if (rx_tick) begin
            rx_cnt <= div;
            if (rx_state == RX_DATA) begin
               rx_sh  <= {rxd_s2, rx_sh[7:1]};
               rx_bit <= rx_bit + 3'd1;
            end
         end else begin
            rx_cnt <= rx_cnt - 16'd1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // RX holding storage
   // ---------------------------------------------------------------------
`ifdef N101_WB8_UART_RXFIFO_EN
   logic [7:0] fifo_mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] count;
   logic       push;

   assign rx_valid = (count != 3'd0);
   assign rx_full  = (count == 3'd4);
   assign rx_head  = rx_valid ? fifo_mem[rd_ptr] : 8'h00;
   assign push     = rx_deliver & (~rx_full | rx_pop);
   assign ovr_set  = rx_deliver & rx_full & ~rx_pop;

   // FIFO storage array, written on push.
   always_ff @(posedge clk) begin
      // NOTE: the data array has no reset; validity is carried entirely by
      // the pointers and count, which are reset.
      if (push)
         fifo_mem[wr_ptr] <= rx_sh;
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 2'd1;
         if (rx_pop)
            rd_ptr <= rd_ptr + 2'd1;
         count <= count + {2'b00, push} - {2'b00, rx_pop};
      end
   end
`else
   logic [7:0] rx_data;
   logic       rx_valid_q;

   assign rx_valid = rx_valid_q;
   assign rx_full  = 1'b0;
   assign rx_head  = rx_valid_q ? rx_data : 8'h00;
   assign ovr_set  = rx_deliver & rx_valid_q & ~rx_pop;

   // Single holding register; a same-cycle pop makes room for the new byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data    <= 8'h00;
         rx_valid_q <= 1'b0;
      end else if (rx_deliver && (!rx_valid_q || rx_pop)) begin
         rx_data    <= rx_sh;
         rx_valid_q <= 1'b1;
      end else if (rx_pop) begin
         rx_valid_q <= 1'b0;
      end
   end
`endif

   // Level interrupt on pending receive data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         uart_irq <= 1'b0;
      else
         uart_irq <= ctrl[2] & rx_valid;
   end

endmodule
